// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pmem_arbiter
// Description : Shares one physical-memory port between the instruction
//               cache and the data cache. Grants one line transaction at a
//               time, latches its command/address/write line, routes the
//               response and read line back to the granted cache only, and
//               counts the cycles a request waits on the other client.
//
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   i_pmem_read/_write/_address/_wdata  icache request (inputs)
//   i_pmem_resp/_rdata             icache response (outputs)
//   d_pmem_read/_write/_address/_wdata  dcache request (inputs)
//   d_pmem_resp/_rdata             dcache response (outputs)
//   pmem_read/_write/_address/_wdata   registered command to memory
//   pmem_resp/_rdata               memory response (inputs)
//   contention_count               saturating wait-cycle counter
//
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_arbiter #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic              i_pmem_resp,
    output logic [LINE_W-1:0] i_pmem_rdata,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [LINE_W-1:0] d_pmem_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,

    output logic [CNT_W-1:0]  contention_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    state_t              r_state;
    logic                r_last_d;      // 1 when the dcache received the most recent grant
    logic                r_pmem_read;
    logic                r_pmem_write;
    logic [ADDR_W-1:0]   r_pmem_address;
    logic [LINE_W-1:0]   r_pmem_wdata;
    logic [CNT_W-1:0]    r_contention;

    logic                w_i_req;
    logic                w_d_req;
    logic                w_grant_d;
    logic                w_other_req;
    logic                w_i_resp;
    logic                w_d_resp;

    assign w_i_req = i_pmem_read | i_pmem_write;
    assign w_d_req = d_pmem_read | d_pmem_write;

    // dcache wins when it is alone, or on a tie when the icache had the last grant.
    assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);

    // The client that is not being served is still asking for the port.
    // In DONE the served client is the one recorded as the last grant.
    always_comb begin
        w_other_req = 1'b0;
        case (r_state)
            S_BUSY_I: w_other_req = w_d_req;
            S_BUSY_D: w_other_req = w_i_req;
            S_DONE:   w_other_req = r_last_d ? w_i_req : w_d_req;
            default:  w_other_req = 1'b0;
        endcase
    end

    // Responses are only forwarded while the owning transaction is in flight.
    assign w_i_resp = (r_state == S_BUSY_I) & pmem_resp;
    assign w_d_resp = (r_state == S_BUSY_D) & pmem_resp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_last_d       <= 1'b1;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        // Read and write together is treated as a write.
                        r_pmem_write   <= d_pmem_write;
                        r_pmem_read    <= d_pmem_read & ~d_pmem_write;
                        r_pmem_address <= d_pmem_address;
                        r_pmem_wdata   <= d_pmem_wdata;
                        r_last_d       <= 1'b1;
                        r_state        <= S_BUSY_D;
                    end else if (w_i_req) begin
                        r_pmem_write   <= i_pmem_write;
                        r_pmem_read    <= i_pmem_read & ~i_pmem_write;
                        r_pmem_address <= i_pmem_address;
                        r_pmem_wdata   <= i_pmem_wdata;
                        r_last_d       <= 1'b0;
                        r_state        <= S_BUSY_I;
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    if (pmem_resp) begin
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Dead cycle so the served cache can drop its request.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_contention <= '0;
        end else if (w_other_req && (r_contention != c_CNT_MAX)) begin
            r_contention <= r_contention + c_CNT_ONE;
        end
    end

    assign i_pmem_resp      = w_i_resp;
    assign d_pmem_resp      = w_d_resp;
    assign i_pmem_rdata     = w_i_resp ? pmem_rdata : '0;
    assign d_pmem_rdata     = w_d_resp ? pmem_rdata : '0;

    assign pmem_read        = r_pmem_read;
    assign pmem_write       = r_pmem_write;
    assign pmem_address     = r_pmem_address;
    assign pmem_wdata       = r_pmem_wdata;
    assign contention_count = r_contention;

endmodule
`default_nettype wire
